// File: rtl/divider_pkg.sv
// Shared types and constants for the iterative signed divider and its control FSM.
package divider_pkg;

    localparam int unsigned DIV_WIDTH   = 32;
    localparam int unsigned DIV_CNT_W   = 6;
    localparam int unsigned DIV_LATENCY = 33;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RUN   = 3'd1,
        FIXUP = 3'd2,
        ZERO  = 3'd3,
        DONE  = 3'd4
    } div_state_e;

endpackage

// File: rtl/divider_if.sv
// Start/done handshake and operand/result bus shared by the divider and its requester.
interface divider_if
    import divider_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) ();

    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             start;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             done;
    logic             div_zero;
    logic             busy;

    modport master (
        output a, b, start,
        input  quotient, remainder, done, div_zero, busy
    );

    modport slave (
        input  a, b, start,
        output quotient, remainder, done, div_zero, busy
    );

endinterface

// File: rtl/div_step.sv
// One restoring-division iteration: trial subtract of the divisor from the shifted partial remainder.
module div_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH:0]   p,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH:0]   p_next,
    output logic [WIDTH-1:0] q_next
);

    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] trial;

    // Extra top bit makes the trial borrow visible even if P ever carried a high bit.
    always_comb begin
        shifted = {p, q[WIDTH-1]};
        trial   = shifted - {2'b00, d};
        if (!trial[WIDTH+1]) begin
            p_next = trial[WIDTH:0];
            q_next = {q[WIDTH-2:0], 1'b1};
        end else begin
            p_next = shifted[WIDTH:0];
            q_next = {q[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/divider.sv
// Iterative signed 32/32 divider: restoring shift-subtract on magnitudes, then sign fixup.
module divider
    import divider_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic      clk,
    input  logic      reset_n,
    divider_if.slave  bus
);

    localparam int unsigned CNT_W = DIV_CNT_W;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    div_state_e       state, state_nxt;

    logic [WIDTH:0]   p_q, p_nxt;
    logic [WIDTH-1:0] q_q, q_nxt;
    logic [WIDTH-1:0] d_q, d_nxt;
    logic [WIDTH-1:0] a_q, a_nxt;
    logic             sign_q_q, sign_q_nxt;
    logic             sign_r_q, sign_r_nxt;
    logic [CNT_W-1:0] cnt_q, cnt_nxt;

    logic [WIDTH-1:0] quo_q, quo_nxt;
    logic [WIDTH-1:0] rem_q, rem_nxt;
    logic             done_q, done_nxt;
    logic             dz_q, dz_nxt;
    logic             busy_q, busy_nxt;

    logic [WIDTH:0]   step_p;
    logic [WIDTH-1:0] step_q;
    logic             accept_c;

    assign accept_c = bus.start && ((state == IDLE) || (state == DONE));

    div_step #(.WIDTH(WIDTH)) u_step (
        .p      (p_q),
        .q      (q_q),
        .d      (d_q),
        .p_next (step_p),
        .q_next (step_q)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: begin
                if (accept_c) begin
                    state_nxt = (bus.b == '0) ? ZERO : RUN;
                end
            end
            RUN:     if (cnt_q == CNT_LAST) state_nxt = FIXUP;
            FIXUP:   state_nxt = DONE;
            ZERO:    state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath and result next-values; everything holds unless the current state updates it.
    always_comb begin
        p_nxt      = p_q;
        q_nxt      = q_q;
        d_nxt      = d_q;
        a_nxt      = a_q;
        sign_q_nxt = sign_q_q;
        sign_r_nxt = sign_r_q;
        cnt_nxt    = cnt_q;
        quo_nxt    = quo_q;
        rem_nxt    = rem_q;
        done_nxt   = done_q;
        dz_nxt     = dz_q;
        case (state)
            IDLE, DONE: begin
                if (accept_c) begin
                    done_nxt   = 1'b0;
                    dz_nxt     = 1'b0;
                    quo_nxt    = '0;
                    rem_nxt    = '0;
                    p_nxt      = '0;
                    q_nxt      = bus.a[WIDTH-1] ? -bus.a : bus.a;
                    d_nxt      = bus.b[WIDTH-1] ? -bus.b : bus.b;
                    a_nxt      = bus.a;
                    sign_q_nxt = bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
                    sign_r_nxt = bus.a[WIDTH-1];
                    cnt_nxt    = '0;
                end
            end
            RUN: begin
                p_nxt   = step_p;
                q_nxt   = step_q;
                cnt_nxt = cnt_q + CNT_W'(1);
            end
            FIXUP: begin
                quo_nxt  = sign_q_q ? -q_q : q_q;
                rem_nxt  = sign_r_q ? -p_q[WIDTH-1:0] : p_q[WIDTH-1:0];
                done_nxt = 1'b1;
                dz_nxt   = 1'b0;
            end
            ZERO: begin
                quo_nxt  = '0;
                rem_nxt  = a_q;
                done_nxt = 1'b1;
                dz_nxt   = 1'b1;
            end
            default: ;
        endcase
        busy_nxt = (state_nxt == RUN) || (state_nxt == FIXUP) || (state_nxt == ZERO);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            p_q      <= '0;
            q_q      <= '0;
            d_q      <= '0;
            a_q      <= '0;
            sign_q_q <= 1'b0;
            sign_r_q <= 1'b0;
            cnt_q    <= '0;
            quo_q    <= '0;
            rem_q    <= '0;
            done_q   <= 1'b0;
            dz_q     <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            p_q      <= p_nxt;
            q_q      <= q_nxt;
            d_q      <= d_nxt;
            a_q      <= a_nxt;
            sign_q_q <= sign_q_nxt;
            sign_r_q <= sign_r_nxt;
            cnt_q    <= cnt_nxt;
            quo_q    <= quo_nxt;
            rem_q    <= rem_nxt;
            done_q   <= done_nxt;
            dz_q     <= dz_nxt;
            busy_q   <= busy_nxt;
        end
    end

    assign bus.quotient  = quo_q;
    assign bus.remainder = rem_q;
    assign bus.done      = done_q;
    assign bus.div_zero  = dz_q;
    assign bus.busy      = busy_q;

endmodule
